// File: rtl/l1_perf_pkg.sv
// Shared definitions for the L1 performance counter bank: event channel names and default widths.
package l1_perf_pkg;

    typedef enum logic [2:0] {
        EVT_HIT         = 3'd0,
        EVT_MISS        = 3'd1,
        EVT_EVICT       = 3'd2,
        EVT_DIRTY_EVICT = 3'd3,
        EVT_PRED_HIT    = 3'd4,
        EVT_PRED_MISS   = 3'd5,
        EVT_STALE       = 3'd6
    } evt_e;

    localparam int EVT_NUM       = 7;
    localparam int L1_PERF_CNT_W = 32;

endpackage

// File: rtl/l1_perf_counter_cell.sv
// One event channel: live counter, shadow copy and sticky overflow flag; updates in the cycle after the edge.
// No backpressure: clr beats read-and-clear beats increment on every edge.
module l1_perf_counter_cell #(
    parameter int CNT_WIDTH = 32,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    input  logic                 snap,
    input  logic                 snap_clr,
    input  logic                 ovf_clr,
    output logic [CNT_WIDTH-1:0] live,
    output logic [CNT_WIDTH-1:0] shadow,
    output logic                 ovf
);

    logic at_max;
    logic zero_now;
    logic ovf_evt;

    assign at_max   = &live;
    assign zero_now = clr | (snap & snap_clr);
    // A counter being cleared this edge drops its event, so it cannot overflow either.
    assign ovf_evt  = inc & at_max & ~zero_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live <= '0;
        end else if (zero_now) begin
            live <= '0;
        end else if (inc) begin
            if (at_max) begin
                live <= SATURATE ? live : '0;
            end else begin
                live <= live + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (snap) begin
            shadow <= live;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (ovf_evt) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/l1_perf_counter_bank.sv
// L1 cache event counter bank with snapshot shadow, indexed read port and overflow interrupt.
// Reads return one cycle after rd_req with no backpressure; irq follows its flag by one cycle.
module l1_perf_counter_bank
    import l1_perf_pkg::*;
#(
    parameter int  NUM_EVENTS = EVT_NUM,
    parameter int  CNT_WIDTH  = L1_PERF_CNT_W,
    parameter bit  SATURATE   = 1'b1,
    localparam int IDX_W      = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_EVENTS-1:0] evt_pulse,
    input  logic [NUM_EVENTS-1:0] evt_en,
    input  logic                  clr,
    input  logic                  snap_req,
    input  logic                  snap_clr,
    input  logic                  rd_req,
    input  logic                  rd_shadow,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic                  rd_valid,
    output logic [CNT_WIDTH-1:0]  rd_data,
    output logic                  rd_err,
    output logic [NUM_EVENTS-1:0] ovf_flags,
    input  logic [NUM_EVENTS-1:0] ovf_clr,
    input  logic [NUM_EVENTS-1:0] irq_en,
    output logic                  irq,
    output logic                  snap_valid
);

    logic [CNT_WIDTH-1:0] live   [NUM_EVENTS];
    logic [CNT_WIDTH-1:0] shadow [NUM_EVENTS];
    logic [CNT_WIDTH-1:0] sel_data;
    logic                 sel_hit;

    for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_cell
        l1_perf_counter_cell #(
            .CNT_WIDTH (CNT_WIDTH),
            .SATURATE  (SATURATE)
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .inc      (evt_pulse[g] & evt_en[g]),
            .clr      (clr),
            .snap     (snap_req),
            .snap_clr (snap_clr),
            .ovf_clr  (ovf_clr[g]),
            .live     (live[g]),
            .shadow   (shadow[g]),
            .ovf      (ovf_flags[g])
        );
    end

    // Indices past the last channel match nothing and are reported through rd_err.
    always_comb begin
        sel_data = '0;
        sel_hit  = 1'b0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (rd_idx == i[IDX_W-1:0]) begin
                sel_hit  = 1'b1;
                sel_data = rd_shadow ? shadow[i] : live[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            rd_data  <= (rd_req & sel_hit) ? sel_data : '0;
            rd_err   <= rd_req & ~sel_hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq        <= 1'b0;
            snap_valid <= 1'b0;
        end else begin
            irq <= |(ovf_flags & irq_en);
            if (snap_req) begin
                snap_valid <= 1'b1;
            end else if (clr) begin
                snap_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_l1_perf_counter_bank.sv
// Drives one 32-bit saturating, one 4-bit saturating and one 4-bit wrapping bank from shared stimulus
// and checks them against directed expectations and an arithmetic reference model.
module tb_l1_perf_counter_bank;
    import l1_perf_pkg::*;

    localparam int N  = 7;
    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] evt_pulse = '0, evt_en = '1, ovf_clr = '0, irq_en = '0;
    logic       clr = 1'b0, snap_req = 1'b0, snap_clr = 1'b0, rd_req = 1'b0, rd_shadow = 1'b0;
    logic [2:0] rd_idx = '0;

    logic        rv_a, rv_b, rv_c, re_a, re_b, re_c, irq_a, irq_b, irq_c, sv_a, sv_b, sv_c;
    logic [31:0] rd_data_a;
    logic [3:0]  rd_data_b, rd_data_c;
    logic [6:0]  ovf_a, ovf_b, ovf_c;

    always #5 clk = ~clk;

    l1_perf_counter_bank #(.NUM_EVENTS(7), .CNT_WIDTH(32), .SATURATE(1'b1)) u_w32s (
        .clk(clk), .rst_n(rst_n), .evt_pulse(evt_pulse), .evt_en(evt_en), .clr(clr),
        .snap_req(snap_req), .snap_clr(snap_clr), .rd_req(rd_req), .rd_shadow(rd_shadow),
        .rd_idx(rd_idx), .rd_valid(rv_a), .rd_data(rd_data_a), .rd_err(re_a), .ovf_flags(ovf_a),
        .ovf_clr(ovf_clr), .irq_en(irq_en), .irq(irq_a), .snap_valid(sv_a));

    l1_perf_counter_bank #(.NUM_EVENTS(7), .CNT_WIDTH(4), .SATURATE(1'b1)) u_w4s (
        .clk(clk), .rst_n(rst_n), .evt_pulse(evt_pulse), .evt_en(evt_en), .clr(clr),
        .snap_req(snap_req), .snap_clr(snap_clr), .rd_req(rd_req), .rd_shadow(rd_shadow),
        .rd_idx(rd_idx), .rd_valid(rv_b), .rd_data(rd_data_b), .rd_err(re_b), .ovf_flags(ovf_b),
        .ovf_clr(ovf_clr), .irq_en(irq_en), .irq(irq_b), .snap_valid(sv_b));

    l1_perf_counter_bank #(.NUM_EVENTS(7), .CNT_WIDTH(4), .SATURATE(1'b0)) u_w4w (
        .clk(clk), .rst_n(rst_n), .evt_pulse(evt_pulse), .evt_en(evt_en), .clr(clr),
        .snap_req(snap_req), .snap_clr(snap_clr), .rd_req(rd_req), .rd_shadow(rd_shadow),
        .rd_idx(rd_idx), .rd_valid(rv_c), .rd_data(rd_data_c), .rd_err(re_c), .ovf_flags(ovf_c),
        .ovf_clr(ovf_clr), .irq_en(irq_en), .irq(irq_c), .snap_valid(sv_c));

    logic [63:0] obs_data  [NI];
    logic        obs_valid [NI];
    logic        obs_err   [NI];
    logic        obs_irq   [NI];
    logic        obs_sv    [NI];
    logic [6:0]  obs_ovf   [NI];

    assign obs_data[0] = {32'd0, rd_data_a};
    assign obs_data[1] = {60'd0, rd_data_b};
    assign obs_data[2] = {60'd0, rd_data_c};
    assign obs_valid[0] = rv_a;  assign obs_valid[1] = rv_b;  assign obs_valid[2] = rv_c;
    assign obs_err[0]   = re_a;  assign obs_err[1]   = re_b;  assign obs_err[2]   = re_c;
    assign obs_irq[0]   = irq_a; assign obs_irq[1]   = irq_b; assign obs_irq[2]   = irq_c;
    assign obs_sv[0]    = sv_a;  assign obs_sv[1]    = sv_b;  assign obs_sv[2]    = sv_c;
    assign obs_ovf[0]   = ovf_a; assign obs_ovf[1]   = ovf_b; assign obs_ovf[2]   = ovf_c;

    // Reference model: counts as plain integers bounded by 2**width-1.
    longint unsigned m_max [NI] = '{64'hFFFF_FFFF, 64'd15, 64'd15};
    bit              m_sat [NI] = '{1'b1, 1'b1, 1'b0};
    string           nm    [NI] = '{"w32s", "w4s", "w4w"};
    longint unsigned m_live [NI][N];
    longint unsigned m_shadow [NI][N];
    longint unsigned m_rdata [NI];
    logic [6:0]      m_ovf [NI];
    bit              m_irq [NI], m_sv [NI], m_rv [NI], m_rerr [NI];

    int checks = 0;
    int passed = 0;

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < N; i++) begin
                m_live[k][i]   = 0;
                m_shadow[k][i] = 0;
            end
            m_ovf[k] = '0; m_irq[k] = 0; m_sv[k] = 0; m_rv[k] = 0; m_rerr[k] = 0; m_rdata[k] = 0;
        end
    endtask

    task automatic model_edge();
        bit inc, zero;
        for (int k = 0; k < NI; k++) begin
            m_rv[k]    = rd_req;
            m_rerr[k]  = 0;
            m_rdata[k] = 0;
            if (rd_req) begin
                if (int'(rd_idx) < N)
                    m_rdata[k] = rd_shadow ? m_shadow[k][rd_idx] : m_live[k][rd_idx];
                else
                    m_rerr[k] = 1;
            end
            m_irq[k] = |(m_ovf[k] & irq_en);
            zero = clr || (snap_req && snap_clr);
            for (int i = 0; i < N; i++) begin
                inc = evt_pulse[i] && evt_en[i];
                if (snap_req) m_shadow[k][i] = m_live[k][i];
                if (clr) m_ovf[k][i] = 1'b0;
                else if (inc && !zero && m_live[k][i] == m_max[k]) m_ovf[k][i] = 1'b1;
                else if (ovf_clr[i]) m_ovf[k][i] = 1'b0;
                if (zero) m_live[k][i] = 0;
                else if (inc) m_live[k][i] = (m_live[k][i] == m_max[k]) ?
                                             (m_sat[k] ? m_max[k] : 0) : m_live[k][i] + 1;
            end
            if (snap_req) m_sv[k] = 1;
            else if (clr) m_sv[k] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic do_clear();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; #2 rst_n = 1'b0;
        model_reset();
        rd_req = 1'b1;
        repeat (2) tick();
        for (int k = 0; k < NI; k++) begin
            checks++; if (obs_valid[k] !== 1'b0) $display("FAIL reset_valid %s: got %b want 0", nm[k], obs_valid[k]); else passed++;
            checks++; if (obs_data[k] !== 64'd0) $display("FAIL reset_data %s: got %0h want 0", nm[k], obs_data[k]); else passed++;
            checks++; if (obs_err[k] !== 1'b0) $display("FAIL reset_err %s: got %b want 0", nm[k], obs_err[k]); else passed++;
            checks++; if (obs_ovf[k] !== 7'd0) $display("FAIL reset_ovf %s: got %b want 0", nm[k], obs_ovf[k]); else passed++;
            checks++; if (obs_irq[k] !== 1'b0 || obs_sv[k] !== 1'b0)
                $display("FAIL reset_irq_sv %s: got irq=%b sv=%b want 0,0", nm[k], obs_irq[k], obs_sv[k]); else passed++;
        end
        rd_req = 1'b0;
        rst_n  = 1'b1;
        evt_pulse = 7'b0000001;
        repeat (3) tick();
        rd_req = 1'b1; rd_idx = 3'(EVT_HIT);
        tick();
        checks++; if (rv_a !== 1'b1 || rd_data_a !== 32'd3)
            $display("FAIL pre_reset_read: got v=%b d=%0d want 1,3", rv_a, rd_data_a); else passed++;
        #3 rst_n = 1'b0;
        #1 model_reset();
        for (int k = 0; k < NI; k++) begin
            checks++; if (obs_valid[k] !== 1'b0 || obs_data[k] !== 64'd0)
                $display("FAIL midreset_async %s: got v=%b d=%0h want 0,0", nm[k], obs_valid[k], obs_data[k]); else passed++;
        end
        tick();
        checks++; if (rv_a !== 1'b0) $display("FAIL midreset_hold_valid: got %b want 0", rv_a); else passed++;
        rst_n = 1'b1; rd_req = 1'b0; evt_pulse = '0;
        tick();
    endtask

    task automatic test_basic_count();
        do_clear();
        evt_en = '1;
        evt_pulse = 7'b0000010;
        repeat (5) tick();
        evt_pulse = '0;
        rd_req = 1'b1; rd_shadow = 1'b0; rd_idx = 3'(EVT_MISS);
        tick();
        checks++; if (rv_a !== 1'b1 || rd_data_a !== 32'd5 || re_a !== 1'b0)
            $display("FAIL basic_ch1: got v=%b d=%0d e=%b want 1,5,0", rv_a, rd_data_a, re_a); else passed++;
        rd_idx = 3'(EVT_HIT);
        tick();
        checks++; if (rv_a !== 1'b1 || rd_data_a !== 32'd0)
            $display("FAIL basic_ch0: got v=%b d=%0d want 1,0", rv_a, rd_data_a); else passed++;
        rd_req = 1'b0;
    endtask

    task automatic test_saturate();
        do_clear();
        irq_en = 7'b0000001;
        evt_pulse = 7'b0000001;
        repeat (16) tick();
        checks++; if (ovf_b[0] !== 1'b1 || irq_b !== 1'b0)
            $display("FAIL sat_flag_before_irq: got ovf=%b irq=%b want 1,0", ovf_b[0], irq_b); else passed++;
        tick();
        evt_pulse = '0;
        checks++; if (irq_b !== 1'b1) $display("FAIL sat_irq_rise: got %b want 1", irq_b); else passed++;
        rd_req = 1'b1; rd_idx = 3'(EVT_HIT);
        tick();
        rd_req = 1'b0;
        checks++; if (rd_data_b !== 4'd15) $display("FAIL sat_value: got %0d want 15", rd_data_b); else passed++;
        checks++; if (rd_data_a !== 32'd17) $display("FAIL sat_w32_value: got %0d want 17", rd_data_a); else passed++;
        ovf_clr = 7'b0000001;
        tick();
        ovf_clr = '0;
        checks++; if (ovf_b[0] !== 1'b0) $display("FAIL sat_ovf_clr: got %b want 0", ovf_b[0]); else passed++;
        tick();
        checks++; if (irq_b !== 1'b0) $display("FAIL sat_irq_fall: got %b want 0", irq_b); else passed++;
        irq_en = '0;
    endtask

    task automatic test_wrap();
        do_clear();
        evt_pulse = 7'b0000100;
        repeat (17) tick();
        evt_pulse = '0;
        checks++; if (ovf_c[2] !== 1'b1) $display("FAIL wrap_flag: got %b want 1", ovf_c[2]); else passed++;
        rd_req = 1'b1; rd_idx = 3'(EVT_EVICT);
        tick();
        rd_req = 1'b0;
        checks++; if (rd_data_c !== 4'd1) $display("FAIL wrap_value: got %0d want 1", rd_data_c); else passed++;
        checks++; if (rd_data_b !== 4'd15) $display("FAIL wrap_sat_peer: got %0d want 15", rd_data_b); else passed++;
    endtask

    task automatic test_read_and_clear();
        do_clear();
        evt_pulse = 7'b0001000;
        repeat (9) tick();
        snap_req = 1'b1; snap_clr = 1'b1;
        tick();
        snap_req = 1'b0; snap_clr = 1'b0; evt_pulse = '0;
        checks++; if (sv_a !== 1'b1) $display("FAIL rac_snap_valid: got %b want 1", sv_a); else passed++;
        rd_req = 1'b1; rd_shadow = 1'b1; rd_idx = 3'(EVT_DIRTY_EVICT);
        tick();
        checks++; if (rd_data_a !== 32'd9) $display("FAIL rac_shadow: got %0d want 9", rd_data_a); else passed++;
        rd_shadow = 1'b0;
        tick();
        rd_req = 1'b0;
        checks++; if (rd_data_a !== 32'd0) $display("FAIL rac_live: got %0d want 0", rd_data_a); else passed++;
        do_clear();
        checks++; if (sv_a !== 1'b0) $display("FAIL rac_clr_snap_valid: got %b want 0", sv_a); else passed++;
        rd_req = 1'b1; rd_shadow = 1'b1;
        tick();
        rd_req = 1'b0; rd_shadow = 1'b0;
        checks++; if (rd_data_a !== 32'd9) $display("FAIL rac_shadow_kept: got %0d want 9", rd_data_a); else passed++;
    endtask

    task automatic test_edge_cases();
        logic [2:0] bad_idx;
        bad_idx = 3'd7;
        rd_req = 1'b1; rd_idx = bad_idx;
        tick();
        rd_req = 1'b0;
        checks++; if (rv_a !== 1'b1 || re_a !== 1'b1 || rd_data_a !== 32'd0)
            $display("FAIL bad_idx: got v=%b e=%b d=%0d want 1,1,0", rv_a, re_a, rd_data_a); else passed++;
        do_clear();
        evt_en = 7'b1101111; evt_pulse = 7'b0010000;
        repeat (3) tick();
        evt_en = '1; evt_pulse = '0;
        rd_req = 1'b1; rd_idx = 3'(EVT_PRED_HIT);
        tick();
        rd_req = 1'b0;
        checks++; if (rd_data_a !== 32'd0) $display("FAIL masked_ch4: got %0d want 0", rd_data_a); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] want;
        do_clear();
        evt_pulse = 7'b0000111; tick();
        evt_pulse = 7'b0000110; tick();
        evt_pulse = 7'b0000100; tick();
        evt_pulse = '0;
        rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_idx = 3'(i);
            want = 32'(i + 1);
            tick();
            checks++; if (rv_a !== 1'b1 || rd_data_a !== want)
                $display("FAIL b2b_idx%0d: got v=%b d=%0d want 1,%0d", i, rv_a, rd_data_a, want); else passed++;
        end
        rd_req = 1'b0;
        tick();
        checks++; if (rv_a !== 1'b0 || re_a !== 1'b0)
            $display("FAIL b2b_idle: got v=%b e=%b want 0,0", rv_a, re_a); else passed++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            evt_pulse = 7'($urandom);
            evt_en    = ($urandom_range(3) == 0) ? 7'($urandom) : 7'h7F;
            clr       = ($urandom_range(39) == 0);
            snap_req  = ($urandom_range(14) == 0);
            snap_clr  = 1'($urandom);
            rd_req    = ($urandom_range(2) != 0);
            rd_shadow = 1'($urandom);
            rd_idx    = 3'($urandom);
            ovf_clr   = ($urandom_range(7) == 0) ? 7'($urandom) : 7'd0;
            if ($urandom_range(19) == 0) irq_en = 7'($urandom);
            tick();
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (obs_valid[k] !== m_rv[k] || obs_err[k] !== m_rerr[k] ||
                    (m_rv[k] && obs_data[k] !== m_rdata[k]))
                    $display("FAIL rand_read %s cyc%0d: got v=%b e=%b d=%0h want %b,%b,%0h",
                             nm[k], c, obs_valid[k], obs_err[k], obs_data[k], m_rv[k], m_rerr[k], m_rdata[k]);
                else passed++;
                checks++;
                if (obs_ovf[k] !== m_ovf[k] || obs_irq[k] !== m_irq[k] || obs_sv[k] !== m_sv[k])
                    $display("FAIL rand_status %s cyc%0d: got ovf=%b irq=%b sv=%b want %b,%b,%b",
                             nm[k], c, obs_ovf[k], obs_irq[k], obs_sv[k], m_ovf[k], m_irq[k], m_sv[k]);
                else passed++;
            end
        end
        evt_pulse = '0; clr = 1'b0; snap_req = 1'b0; snap_clr = 1'b0; rd_req = 1'b0; ovf_clr = '0;
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_saturate();
        test_wrap();
        test_read_and_clear();
        test_edge_cases();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
